risc16_exec_core: RTL and testbench

//  Execute/memory/write-back slice of the 16-bit RISC datapath: 8x16 register file (2 read, 1 write),
//  8-function ALU with zero flag, 8-word data memory and the write-back mux.

---
 rtl/risc16_exec_core.sv | 72 +++++++
 tb/tb_risc16_exec_core.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/risc16_exec_core.sv
// risc16_exec_core: execute/memory/write-back slice of the 16-bit RISC datapath
module risc16_exec_core #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int MEM_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write_en,
  input  logic [REG_AW-1:0] reg_write_dest,
  input  logic [REG_AW-1:0] reg_read_addr_1,
  input  logic [REG_AW-1:0] reg_read_addr_2,
  input  logic [DATA_W-1:0] imm,
  input  logic              alu_src,
  input  logic [2:0]        alu_control,
  input  logic              mem_write_en,
  input  logic              mem_read,
  input  logic              mem_to_reg,
  output logic [DATA_W-1:0] reg_read_data_1,
  output logic [DATA_W-1:0] reg_read_data_2,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  output logic [DATA_W-1:0] mem_read_data,
  output logic [DATA_W-1:0] wb_data
);
  logic [DATA_W-1:0] regs [2**REG_AW];
  logic [DATA_W-1:0] mem  [2**MEM_AW];
  logic [DATA_W-1:0] a, b;
  logic [MEM_AW-1:0] addr;

  assign reg_read_data_1 = regs[reg_read_addr_1];
  assign reg_read_data_2 = regs[reg_read_addr_2];
  assign a = reg_read_data_1;
  assign b = alu_src ? imm : reg_read_data_2;

  // shifts by DATA_W or more naturally yield zero
  always_comb begin
    alu_result = '0;
    case (alu_control)
      3'd0: alu_result = a + b;
      3'd1: alu_result = a - b;
      3'd2: alu_result = ~a;
      3'd3: alu_result = a << b;
      3'd4: alu_result = a >> b;
      3'd5: alu_result = a & b;
      3'd6: alu_result = a | b;
      3'd7: alu_result = {{(DATA_W-1){1'b0}}, a < b};
      default: alu_result = '0;
    endcase
  end

  assign zero = alu_result == '0;
  assign addr = alu_result[MEM_AW-1:0];
  assign mem_read_data = mem_read ? mem[addr] : '0;
  assign wb_data = mem_to_reg ? mem_read_data : alu_result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
    end else if (reg_write_en) begin
      regs[reg_write_dest] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**MEM_AW; i++) mem[i] <= '0;
    end else if (mem_write_en) begin
      mem[addr] <= reg_read_data_2;
    end
  end
endmodule

// File: tb/tb_risc16_exec_core.sv
// tb_risc16_exec_core: directed self-checking bench for risc16_exec_core
module tb_risc16_exec_core;
  logic        clk = 0;
  logic        rst_n;
  logic        reg_write_en;
  logic [2:0]  reg_write_dest;
  logic [2:0]  reg_read_addr_1;
  logic [2:0]  reg_read_addr_2;
  logic [15:0] imm;
  logic        alu_src;
  logic [2:0]  alu_control;
  logic        mem_write_en;
  logic        mem_read;
  logic        mem_to_reg;
  logic [15:0] reg_read_data_1;
  logic [15:0] reg_read_data_2;
  logic [15:0] alu_result;
  logic        zero;
  logic [15:0] mem_read_data;
  logic [15:0] wb_data;
  int n_cmp = 0;
  int n_err = 0;

  risc16_exec_core dut (
    .clk(clk), .rst_n(rst_n), .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
    .reg_read_addr_1(reg_read_addr_1), .reg_read_addr_2(reg_read_addr_2), .imm(imm),
    .alu_src(alu_src), .alu_control(alu_control), .mem_write_en(mem_write_en),
    .mem_read(mem_read), .mem_to_reg(mem_to_reg), .reg_read_data_1(reg_read_data_1),
    .reg_read_data_2(reg_read_data_2), .alu_result(alu_result), .zero(zero),
    .mem_read_data(mem_read_data), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // R7 is never written, so it serves as a zero operand
  task automatic alu(input logic [2:0] ra, input logic [2:0] rb, input logic src,
                     input logic [15:0] v, input logic [2:0] op);
    reg_read_addr_1 = ra;
    reg_read_addr_2 = rb;
    alu_src = src;
    imm = v;
    alu_control = op;
    #1;
  endtask

  task automatic wreg(input logic [2:0] d, input logic [15:0] v);
    alu(3'd7, 3'd0, 1'b1, v, 3'd0);
    mem_to_reg = 0;
    reg_write_dest = d;
    reg_write_en = 1;
    tick();
    reg_write_en = 0;
  endtask

  task automatic rdreg(input string tag, input logic [2:0] r, input logic [15:0] exp);
    reg_read_addr_1 = r;
    #1;
    chk(tag, reg_read_data_1, exp);
  endtask

  task automatic rdmem(input string tag, input logic [15:0] ad, input logic [15:0] exp);
    alu(3'd7, 3'd0, 1'b1, ad, 3'd0);
    mem_read = 1;
    #1;
    chk(tag, mem_read_data, exp);
  endtask

  initial begin
    rst_n = 0; reg_write_en = 0; reg_write_dest = 0; reg_read_addr_1 = 0;
    reg_read_addr_2 = 0; imm = 0; alu_src = 0; alu_control = 0;
    mem_write_en = 0; mem_read = 0; mem_to_reg = 0;
    tick(); tick();
    rst_n = 1;
    alu(3'd0, 3'd0, 1'b0, 16'h0, 3'd0);
    chk("rst_alu", alu_result, 16'h0000);
    chk("rst_zero", {15'd0, zero}, 16'h0001);

    wreg(3'd3, 16'h1234);
    rdreg("r3_write", 3'd3, 16'h1234);
    alu(3'd7, 3'd3, 1'b1, 16'h1234, 3'd0);
    mem_write_en = 1;
    tick();
    mem_write_en = 0;
    rdmem("mem4_pre_rst", 16'h0004, 16'h1234);
    mem_read = 0;

    // reset edge with writes requested: both must be suppressed
    rst_n = 0;
    alu(3'd7, 3'd3, 1'b1, 16'h5555, 3'd0);
    reg_write_dest = 3'd3; reg_write_en = 1; mem_write_en = 1;
    tick();
    rst_n = 1; reg_write_en = 0; mem_write_en = 0;
    rdreg("r3_after_rst", 3'd3, 16'h0000);
    for (int i = 0; i < 8; i++) rdmem($sformatf("mem%0d_rst", i), 16'(i), 16'h0000);
    mem_read = 0;

    wreg(3'd2, 16'h00FF);
    wreg(3'd5, 16'h0F0F);
    alu(3'd2, 3'd5, 1'b0, 16'h0, 3'd5);
    chk("and_r2_r5", alu_result, 16'h000F);
    alu(3'd2, 3'd5, 1'b0, 16'h0, 3'd6);
    chk("or_r2_r5", alu_result, 16'h0FFF);

    alu(3'd7, 3'd2, 1'b1, 16'hAAAA, 3'd0);
    reg_write_dest = 3'd2; reg_write_en = 1;
    #1;
    chk("r2_same_cycle_old", reg_read_data_2, 16'h00FF);
    tick();
    reg_write_en = 0;
    #1;
    chk("r2_after_write", reg_read_data_2, 16'hAAAA);

    wreg(3'd1, 16'hFFFF);
    alu(3'd1, 3'd0, 1'b1, 16'h0001, 3'd0);
    chk("add_wrap", alu_result, 16'h0000);
    chk("add_wrap_zero", {15'd0, zero}, 16'h0001);
    alu(3'd7, 3'd0, 1'b1, 16'h0001, 3'd1);
    chk("sub_wrap", alu_result, 16'hFFFF);
    chk("sub_wrap_zero", {15'd0, zero}, 16'h0000);
    wreg(3'd4, 16'h00FF);
    alu(3'd4, 3'd0, 1'b1, 16'h0, 3'd2);
    chk("not", alu_result, 16'hFF00);
    wreg(3'd6, 16'h0001);
    alu(3'd6, 3'd0, 1'b1, 16'd4, 3'd3);
    chk("sll4", alu_result, 16'h0010);
    wreg(3'd5, 16'h8000);
    alu(3'd5, 3'd0, 1'b1, 16'd15, 3'd4);
    chk("srl15", alu_result, 16'h0001);
    alu(3'd6, 3'd0, 1'b1, 16'd16, 3'd3);
    chk("sll16", alu_result, 16'h0000);
    alu(3'd5, 3'd0, 1'b1, 16'd16, 3'd4);
    chk("srl16", alu_result, 16'h0000);
    alu(3'd6, 3'd0, 1'b1, 16'hFFFF, 3'd7);
    chk("slt_1_ffff", alu_result, 16'h0001);
    alu(3'd1, 3'd0, 1'b1, 16'h0001, 3'd7);
    chk("slt_ffff_1", alu_result, 16'h0000);

    wreg(3'd3, 16'h0005);
    alu(3'd3, 3'd0, 1'b1, 16'hFFFE, 3'd0);
    chk("imm_add", alu_result, 16'h0003);

    wreg(3'd1, 16'h000A);
    wreg(3'd4, 16'hBEEF);
    alu(3'd1, 3'd4, 1'b1, 16'h0, 3'd0);
    mem_write_en = 1;
    tick();
    mem_write_en = 0;
    rdmem("mem2_store", 16'h0002, 16'hBEEF);
    mem_to_reg = 1; reg_write_dest = 3'd6; reg_write_en = 1;
    #1;
    chk("load_wb", wb_data, 16'hBEEF);
    tick();
    reg_write_en = 0;
    rdreg("r6_loaded", 3'd6, 16'hBEEF);
    alu(3'd7, 3'd0, 1'b1, 16'h0002, 3'd0);
    mem_read = 0;
    #1;
    chk("mem_read_off", mem_read_data, 16'h0000);
    chk("wb_mem_read_off", wb_data, 16'h0000);
    mem_to_reg = 0;

    alu(3'd7, 3'd4, 1'b1, 16'h0003, 3'd0);
    mem_read = 1; mem_write_en = 1; reg_write_en = 1; reg_write_dest = 3'd0;
    #1;
    chk("simul_mem_old", mem_read_data, 16'h0000);
    tick();
    mem_write_en = 0; reg_write_en = 0;
    #1;
    chk("simul_mem_new", mem_read_data, 16'hBEEF);
    rdreg("simul_r0", 3'd0, 16'h0003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
